// File: rtl/watchdog_pkg.sv
// Shared types and constants for the system watchdog: FSM states, register map,
// CTRL bit positions and default kick keys.
package watchdog_pkg;

  typedef enum logic [1:0] {
    WDT_IDLE = 2'd0,
    WDT_RUN  = 2'd1,
    WDT_FIRE = 2'd2
  } wdt_state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_KEY    = 2'd2;
  localparam logic [1:0] ADDR_PRESC  = 2'd3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_LOCK = 1;

  localparam logic [7:0]  DEF_KEY_ARM    = 8'h55;
  localparam logic [7:0]  DEF_KEY_FIRE   = 8'hAA;
  localparam int unsigned DEF_PULSE_LEN  = 16;
  localparam int unsigned DEF_WARN_TICKS = 4;

endpackage

// File: rtl/wdt_prescaler.sv
// Cycle divider for the watchdog countdown: counts 0..div and emits tick on wrap,
// giving one tick every div+1 cycles. clr holds the counter at zero.
module wdt_prescaler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] r_cnt;

  // >= rather than == so a divisor lowered below the current count still wraps
  assign tick = (r_cnt >= div);

  always_ff @(posedge CLK) begin
    if (!RST || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/watchdog_ctrl.sv
// Bus-programmable watchdog sequencer: register file, kick-key unlock, countdown FSM
// and RSTOUT pulse. Define WDT_WARN_EN to add the registered early-warning output.
module watchdog_ctrl
  import watchdog_pkg::*;
#(
  parameter int unsigned PULSE_LEN  = DEF_PULSE_LEN,
  parameter logic [7:0]  KEY_ARM    = DEF_KEY_ARM,
  parameter logic [7:0]  KEY_FIRE   = DEF_KEY_FIRE
`ifdef WDT_WARN_EN
  ,
  parameter int unsigned WARN_TICKS = DEF_WARN_TICKS
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] ABUS,
  input  logic [7:0] DBUS,
  input  logic       WR,
  output logic       RSTOUT,
  output logic       RUNNING,
  output logic [7:0] COUNT,
  output logic       WARN
);

  localparam int unsigned PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  wdt_state_t     r_state, w_state_nxt;
  logic           r_en, r_lock, r_armed, w_armed_nxt;
  logic [7:0]     r_reload, r_presc, r_count, w_count_nxt;
  logic [PCW-1:0] r_pcnt;
  logic           w_wr_ctrl, w_wr_reload, w_wr_presc, w_wr_key;
  logic           w_en, w_en_drop, w_kick, w_tick, w_clr, w_pulse_done;

  assign w_wr_ctrl    = WR && (ABUS == ADDR_CTRL)   && !r_lock;
  assign w_wr_reload  = WR && (ABUS == ADDR_RELOAD) && !r_lock;
  assign w_wr_presc   = WR && (ABUS == ADDR_PRESC)  && !r_lock;
  assign w_wr_key     = WR && (ABUS == ADDR_KEY)    && (r_state == WDT_RUN);
  // EN acts in the cycle it is written so an EN=0 write wins over a same-cycle expiring tick
  assign w_en         = w_wr_ctrl ? DBUS[CTRL_EN] : r_en;
  assign w_pulse_done = (r_pcnt == PCW'(PULSE_LEN - 1));
  assign w_clr        = (r_state != WDT_RUN) || w_kick;

  wdt_prescaler u_presc (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (w_clr),
    .div  (r_presc),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_armed_nxt = r_armed;
    w_kick      = 1'b0;
    w_en_drop   = 1'b0;
    case (r_state)
      WDT_IDLE: begin
        w_armed_nxt = 1'b0;
        if (w_en) begin
          w_state_nxt = WDT_RUN;
          w_count_nxt = r_reload;
        end
      end
      WDT_RUN: begin
        if (!w_en) begin
          w_state_nxt = WDT_IDLE;
          w_count_nxt = '0;
          w_armed_nxt = 1'b0;
        end else if (w_wr_key && (DBUS == KEY_FIRE) && r_armed) begin
          w_count_nxt = r_reload;
          w_armed_nxt = 1'b0;
          w_kick      = 1'b1;
        end else if (w_wr_key && (DBUS != KEY_ARM)) begin
          w_state_nxt = WDT_FIRE;
          w_armed_nxt = 1'b0;
        end else begin
          if (w_wr_key) w_armed_nxt = 1'b1;
          if (w_tick) begin
            if (r_count == '0) begin
              w_state_nxt = WDT_FIRE;
              w_armed_nxt = 1'b0;
            end else begin
              w_count_nxt = r_count - 8'd1;
            end
          end
        end
      end
      WDT_FIRE: begin
        w_armed_nxt = 1'b0;
        if (w_pulse_done) begin
          if (r_lock) begin
            w_state_nxt = WDT_RUN;
            w_count_nxt = r_reload;
          end else begin
            w_state_nxt = WDT_IDLE;
            w_count_nxt = '0;
            w_en_drop   = 1'b1;
          end
        end
      end
      default: w_state_nxt = WDT_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= WDT_IDLE;
      r_en     <= 1'b0;
      r_lock   <= 1'b0;
      r_reload <= 8'hFF;
      r_presc  <= 8'hFF;
      r_count  <= '0;
      r_armed  <= 1'b0;
      r_pcnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_armed <= w_armed_nxt;
      r_en    <= w_en_drop ? 1'b0 : w_en;
      r_lock  <= r_lock | (w_wr_ctrl & DBUS[CTRL_LOCK]);
      if (w_wr_reload) r_reload <= DBUS;
      if (w_wr_presc)  r_presc  <= DBUS;
      r_pcnt  <= ((r_state == WDT_FIRE) && !w_pulse_done) ? r_pcnt + PCW'(1) : '0;
    end
  end

  assign RSTOUT  = (r_state == WDT_FIRE);
  assign RUNNING = (r_state == WDT_RUN);
  assign COUNT   = r_count;

`ifdef WDT_WARN_EN
  logic r_warn;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= (w_state_nxt == WDT_RUN) && !w_kick && (w_count_nxt <= 8'(WARN_TICKS));
    end
  end
  assign WARN = r_warn;
`else
  assign WARN = 1'b0;
`endif

endmodule

// File: tb/tb_watchdog_ctrl.sv
// Self-checking bench for watchdog_ctrl: directed scenarios plus randomized bus traffic,
// all compared against a cycle-level behavioural model of the watchdog rules.
module tb_watchdog_ctrl;

  localparam int PULSE = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR = 1'b0;
  logic [1:0] ABUS = 2'd0;
  logic [7:0] DBUS = 8'd0;
  logic       RSTOUT, RUNNING, WARN;
  logic [7:0] COUNT;

  int n_checks = 0;
  int n_errors = 0;

  // model state: mode 0 idle, 1 run, 2 fire; phase = cycles since last prescaler restart/tick
  int m_mode, m_reload, m_presc, m_count, m_phase, m_fire_left;
  bit m_en, m_lock, m_armed, m_warn;

  watchdog_ctrl #(.PULSE_LEN(16), .KEY_ARM(8'h55), .KEY_FIRE(8'hAA)) dut (
    .CLK(CLK), .RST(RST), .ABUS(ABUS), .DBUS(DBUS), .WR(WR),
    .RSTOUT(RSTOUT), .RUNNING(RUNNING), .COUNT(COUNT), .WARN(WARN)
  );

  always #5 CLK = ~CLK;

  task automatic model_edge(input bit rst, input bit wr, input bit [1:0] a, input bit [7:0] d);
    bit ctrl_w, key_w, en, kicked, tick;
    if (!rst) begin
      m_mode = 0; m_en = 0; m_lock = 0; m_reload = 255; m_presc = 255;
      m_count = 0; m_phase = 0; m_armed = 0; m_fire_left = 0; m_warn = 0;
      return;
    end
    ctrl_w = wr && (a == 2'd0) && !m_lock;
    key_w  = wr && (a == 2'd2) && (m_mode == 1);
    en     = ctrl_w ? d[0] : m_en;
    kicked = 0;
    if (m_mode == 0) begin
      m_armed = 0;
      if (en) begin m_mode = 1; m_count = m_reload; m_phase = 0; end
    end else if (m_mode == 1) begin
      tick = (m_phase == m_presc);
      m_phase = tick ? 0 : m_phase + 1;
      if (!en) begin
        m_mode = 0; m_count = 0; m_armed = 0;
      end else if (key_w && d == 8'hAA && m_armed) begin
        m_count = m_reload; m_phase = 0; m_armed = 0; kicked = 1;
      end else if (key_w && d != 8'h55) begin
        m_mode = 2; m_fire_left = PULSE; m_armed = 0;
      end else begin
        if (key_w) m_armed = 1;
        if (tick) begin
          if (m_count == 0) begin m_mode = 2; m_fire_left = PULSE; m_armed = 0; end
          else m_count = m_count - 1;
        end
      end
    end else begin
      m_fire_left = m_fire_left - 1;
      if (m_fire_left == 0) begin
        if (m_lock) begin m_mode = 1; m_count = m_reload; m_phase = 0; end
        else begin m_mode = 0; m_count = 0; en = 0; end
      end
    end
    m_en = en;
    if (wr && a == 2'd1 && !m_lock) m_reload = d;
    if (wr && a == 2'd3 && !m_lock) m_presc = d;
    if (ctrl_w && d[1]) m_lock = 1;
    m_warn = (m_mode == 1) && (m_count <= 4) && !kicked;
  endtask

  task automatic drive(input bit rst, input bit wr, input bit [1:0] a, input bit [7:0] d);
    RST = rst; WR = wr; ABUS = a; DBUS = d;
    model_edge(rst, wr, a, d);
    @(posedge CLK);
    #1;
    RST = 1'b1; WR = 1'b0;
  endtask

  function automatic logic [2:0] exp_flags();
`ifdef WDT_WARN_EN
    return {m_mode == 2, m_mode == 1, m_warn};
`else
    return {m_mode == 2, m_mode == 1, 1'b0};
`endif
  endfunction

  task automatic test_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_checks++;
    if ({RSTOUT, RUNNING, WARN} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags got %b exp 000", {RSTOUT, RUNNING, WARN});
    end
    n_checks++;
    if (COUNT !== 8'd0) begin
      n_errors++; $display("FAIL reset_count got %0d exp 0", COUNT);
    end
  endtask

  task automatic test_expiry();
    drive(1, 1, 2'd1, 8'd3);
    drive(1, 1, 2'd3, 8'd0);
    drive(1, 1, 2'd0, 8'd1);
    for (int i = 3; i >= 0; i--) begin
      n_checks++;
      if (COUNT !== 8'(i) || RUNNING !== 1'b1) begin
        n_errors++; $display("FAIL expiry_count got %0d/%b exp %0d/1", COUNT, RUNNING, i);
      end
      drive(1, 0, 0, 0);
    end
    for (int i = 0; i < PULSE + 4; i++) begin
      n_checks++;
      if (RSTOUT !== (i < PULSE) || RUNNING !== 1'b0) begin
        n_errors++; $display("FAIL expiry_pulse cyc %0d got %b/%b exp %b/0", i, RSTOUT, RUNNING, i < PULSE);
      end
      n_checks++;
      if ({RSTOUT, RUNNING, WARN} !== exp_flags()) begin
        n_errors++; $display("FAIL expiry_model cyc %0d got %b exp %b", i, {RSTOUT, RUNNING, WARN}, exp_flags());
      end
      drive(1, 0, 0, 0);
    end
  endtask

  task automatic test_kick();
    int guard;
    drive(1, 1, 2'd1, 8'd10);
    drive(1, 1, 2'd3, 8'd1);
    drive(1, 1, 2'd0, 8'd1);
    guard = 0;
    while (m_count != 2 && guard < 100) begin
      drive(1, 0, 0, 0);
      guard++;
      n_checks++;
      if (COUNT !== 8'(m_count) || {RSTOUT, RUNNING, WARN} !== exp_flags()) begin
        n_errors++; $display("FAIL kick_run got %0d/%b exp %0d/%b", COUNT, {RSTOUT, RUNNING, WARN}, m_count, exp_flags());
      end
    end
    n_checks++;
    if (guard >= 100) begin n_errors++; $display("FAIL kick_timeout got %0d exp <100", guard); end
    drive(1, 1, 2'd2, 8'h55);
    drive(1, 1, 2'd2, 8'hAA);
    n_checks++;
    if (COUNT !== 8'd10 || RSTOUT !== 1'b0 || RUNNING !== 1'b1) begin
      n_errors++; $display("FAIL kick_reload got %0d/%b exp 10/0", COUNT, RSTOUT);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 0);
      n_checks++;
      if (RSTOUT !== 1'b0 || COUNT !== 8'(m_count)) begin
        n_errors++; $display("FAIL kick_after got %b/%0d exp 0/%0d", RSTOUT, COUNT, m_count);
      end
    end
  endtask

  task automatic test_bad_key();
    bit [7:0] bad [2] = '{8'h12, 8'hAA};
    for (int k = 0; k < 2; k++) begin
      if (m_mode != 1) drive(1, 1, 2'd0, 8'd1);
      drive(1, 1, 2'd2, bad[k]);
      for (int i = 0; i <= PULSE; i++) begin
        n_checks++;
        if (RSTOUT !== (i < PULSE) || {RSTOUT, RUNNING, WARN} !== exp_flags()) begin
          n_errors++; $display("FAIL badkey_%0h cyc %0d got %b exp %b", bad[k], i, {RSTOUT, RUNNING, WARN}, exp_flags());
        end
        drive(1, 0, 0, 0);
      end
    end
  endtask

  task automatic test_simultaneous();
    int guard;
    drive(1, 1, 2'd1, 8'd2);
    drive(1, 1, 2'd3, 8'd3);
    drive(1, 1, 2'd0, 8'd1);
    guard = 0;
    while (!(m_count == 0 && m_phase == 0) && guard < 50) begin drive(1, 0, 0, 0); guard++; end
    drive(1, 1, 2'd2, 8'h55);
    while (m_phase != m_presc && guard < 50) begin drive(1, 0, 0, 0); guard++; end
    n_checks++;
    if (guard >= 50 || COUNT !== 8'd0) begin
      n_errors++; $display("FAIL simul_setup got %0d/%0d exp 0/<50", COUNT, guard);
    end
    drive(1, 1, 2'd2, 8'hAA);
    n_checks++;
    if (COUNT !== 8'd2 || RSTOUT !== 1'b0 || RUNNING !== 1'b1) begin
      n_errors++; $display("FAIL simul_kick got %0d/%b/%b exp 2/0/1", COUNT, RSTOUT, RUNNING);
    end
    guard = 0;
    while (!(m_count == 0 && m_phase == m_presc) && guard < 50) begin drive(1, 0, 0, 0); guard++; end
    drive(1, 1, 2'd0, 8'd0);
    n_checks++;
    if (guard >= 50 || RSTOUT !== 1'b0 || RUNNING !== 1'b0 || COUNT !== 8'd0) begin
      n_errors++; $display("FAIL simul_en_off got %b/%b/%0d exp 0/0/0", RSTOUT, RUNNING, COUNT);
    end
  endtask

  task automatic test_lock_and_reset();
    int guard;
    drive(0, 0, 0, 0);
    drive(1, 1, 2'd1, 8'd4);
    drive(1, 1, 2'd3, 8'd0);
    drive(1, 1, 2'd0, 8'd3);
    drive(1, 1, 2'd0, 8'd0);
    drive(1, 1, 2'd1, 8'd5);
    n_checks++;
    if (RUNNING !== 1'b1) begin n_errors++; $display("FAIL lock_ctrl got %b exp 1", RUNNING); end
    guard = 0;
    while (m_mode != 2 && guard < 50) begin drive(1, 0, 0, 0); guard++; end
    while (m_mode == 2 && guard < 50) begin drive(1, 0, 0, 0); guard++; end
    n_checks++;
    if (guard >= 50 || RUNNING !== 1'b1 || COUNT !== 8'd4) begin
      n_errors++; $display("FAIL lock_rerun got %b/%0d exp 1/4", RUNNING, COUNT);
    end
    guard = 0;
    while (m_mode != 2 && guard < 50) begin drive(1, 0, 0, 0); guard++; end
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
    n_checks++;
    if (RSTOUT !== 1'b1) begin n_errors++; $display("FAIL midfire_pre got %b exp 1", RSTOUT); end
    drive(0, 0, 0, 0);
    n_checks++;
    if ({RSTOUT, RUNNING, WARN} !== 3'b000 || COUNT !== 8'd0) begin
      n_errors++; $display("FAIL midfire_rst got %b/%0d exp 000/0", {RSTOUT, RUNNING, WARN}, COUNT);
    end
    drive(1, 1, 2'd0, 8'd1);
    n_checks++;
    if (COUNT !== 8'hFF || RUNNING !== 1'b1) begin
      n_errors++; $display("FAIL rst_reload got %0d/%b exp 255/1", COUNT, RUNNING);
    end
    drive(1, 1, 2'd0, 8'd0);
  endtask

`ifdef WDT_WARN_EN
  task automatic test_warn();
    bit seen;
    drive(0, 0, 0, 0);
    drive(1, 1, 2'd1, 8'd6);
    drive(1, 1, 2'd3, 8'd0);
    drive(1, 1, 2'd0, 8'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (WARN !== (m_mode == 1 && m_count <= 4)) begin
        n_errors++; $display("FAIL warn_level got %b exp %b", WARN, m_mode == 1 && m_count <= 4);
      end
      if (WARN === 1'b1 && !seen) begin
        seen = 1;
        n_checks++;
        if (COUNT !== 8'd4) begin n_errors++; $display("FAIL warn_rise got %0d exp 4", COUNT); end
      end
      drive(1, 0, 0, 0);
    end
  endtask
`endif

  task automatic test_random();
    bit [1:0] a;
    bit [7:0] d;
    bit wr;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      wr = ($urandom_range(0, 2) != 0);
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0: d = {6'($urandom), ($urandom_range(0, 40) == 0), ($urandom_range(0, 7) != 0)};
        2'd1: d = 8'($urandom_range(0, 12));
        2'd2: d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : (($urandom_range(0, 1) != 0) ? 8'h55 : 8'hAA);
        default: begin d = 8'($urandom_range(0, 3)); if (m_mode == 1) wr = 0; end
      endcase
      drive(($urandom_range(0, 199) != 0), wr, a, d);
      n_checks++;
      if ({RSTOUT, RUNNING, WARN} !== exp_flags()) begin
        n_errors++; $display("FAIL rand_flags cyc %0d got %b exp %b", i, {RSTOUT, RUNNING, WARN}, exp_flags());
      end
      if (m_mode != 2) begin
        n_checks++;
        if (COUNT !== 8'(m_count)) begin
          n_errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", i, COUNT, m_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_kick();
    test_bad_key();
    test_simultaneous();
    test_lock_and_reset();
`ifdef WDT_WARN_EN
    test_warn();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
